// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encoding and legal WIDTH bounds for the serial adder.
package serial_adder_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: single-bit combinational full adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder/subtractor with start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t state, state_nx;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CNT_W-1:0] cnt;
  logic carry, msb_ci, s, co, accept, last;
  full_adder_cell u_fa (.a(sh_a[0]), .b(sh_b[0]), .ci(carry), .s(s), .co(co));
  always_comb begin
    accept   = state == S_IDLE && start;
    last     = state == S_SHIFT && cnt == CNT_W'(WIDTH - 1);
    state_nx = accept ? S_SHIFT : state == S_SHIFT ? (last ? S_DONE : S_SHIFT) : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  // Subtraction is A + ~B + 1: B is inverted at load and carry seeded with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      sum    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      msb_ci <= 1'b0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (accept) begin
      sh_a   <= a;
      sh_b   <= sub ? ~b : b;
      carry  <= sub | cin;
      cnt    <= '0;
      sum    <= '0;
      msb_ci <= 1'b0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      busy   <= 1'b1;
      done   <= 1'b0;
    end else if (state == S_SHIFT) begin
      sum   <= {s, sum[WIDTH-1:1]};
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      carry <= co;
      cnt   <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(WIDTH - 2)) msb_ci <= co;
      if (last) begin
        cout <= co;
        ovf  <= msb_ci ^ co;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, random and exhaustive checks of serial_adder against an arithmetic model.
module tb_serial_adder;
  typedef struct {
    logic [7:0] a, b;
    bit         sub, cin;
    logic [7:0] es;
    bit         ec, eo;
  } vec_t;
  logic clk = 0, rst_n = 0, start8 = 0, start2 = 0, sub = 0, cin = 0;
  logic [7:0] a = 0, b = 0, sum8;
  logic [1:0] sum2;
  logic cout8, ovf8, busy8, done8, cout2, ovf2, busy2, done2;
  int checks = 0, failures = 0;
  vec_t vecs[6];
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub), .a(a), .b(b), .cin(cin),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
  );
  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub), .a(a[1:0]), .b(b[1:0]), .cin(cin),
    .sum(sum2), .cout(cout2), .ovf(ovf2), .busy(busy2), .done(done2)
  );
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic void model(input int w, input int ua, input int ub, input bit s, input bit c,
                                output int sm, output bit co, output bit ov);
    longint m, u, sa, sb, sv, cc;
    m  = longint'(1) << w;
    cc = longint'(c);
    u  = s ? ua + (m - 1 - ub) + 1 : ua + ub + cc;
    sm = int'(u % m);
    co = u >= m;
    sa = ua >= m / 2 ? ua - m : ua;
    sb = ub >= m / 2 ? ub - m : ub;
    sv = s ? sa - sb : sa + sb + cc;
    ov = sv < -(m / 2) || sv >= m / 2;
  endfunction
  // Called at a negedge with the selected DUT idle; returns at the negedge after the done cycle.
  task automatic run_op(input bit w2, input logic [7:0] ta, input logic [7:0] tb, input bit ts,
                        input bit tc, input int es, input bit ec, input bit eo);
    int lat;
    bit bad_busy;
    int w;
    w = w2 ? 2 : 8;
    lat = -1;
    bad_busy = 0;
    a = ta; b = tb; sub = ts; cin = tc;
    if (w2) start2 = 1; else start8 = 1;
    @(negedge clk);
    start2 = 0; start8 = 0;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    for (int k = 0; k <= 40; k++) begin
      if (w2 ? done2 : done8) begin
        lat = k;
        chk("sum", w2 ? int'(sum2) : int'(sum8), es);
        chk("cout", w2 ? int'(cout2) : int'(cout8), int'(ec));
        chk("ovf", w2 ? int'(ovf2) : int'(ovf8), int'(eo));
        break;
      end
      if (!(w2 ? busy2 : busy8)) bad_busy = 1;
      @(negedge clk);
    end
    chk("latency", lat, w);
    chk("busy_span", int'(bad_busy), 0);
    if (lat >= 0) begin
      @(negedge clk);
      chk("done_pulse", w2 ? int'(done2) : int'(done8), 0);
      chk("busy_after", w2 ? int'(busy2) : int'(busy8), 0);
      chk("sum_hold", w2 ? int'(sum2) : int'(sum8), es);
    end
  endtask
  initial begin
    int es, ndone, lat;
    bit ec, eo;
    logic [7:0] ra, rb;
    bit rs, rc;
    vecs[0] = '{8'h3C, 8'h05, 0, 0, 8'h41, 0, 0};
    vecs[1] = '{8'hFF, 8'h01, 0, 1, 8'h01, 1, 0};
    vecs[2] = '{8'h7F, 8'h01, 0, 0, 8'h80, 0, 1};
    vecs[3] = '{8'h05, 8'h07, 1, 0, 8'hFE, 0, 0};
    vecs[4] = '{8'h80, 8'h01, 1, 0, 8'h7F, 1, 1};
    vecs[5] = '{8'h05, 8'h07, 1, 1, 8'hFE, 0, 0};
    repeat (2) @(negedge clk);
    chk("rst_sum", int'(sum8), 0);
    chk("rst_flags", int'({cout8, ovf8, busy8, done8}), 0);
    chk("rst_w2", int'({sum2, cout2, ovf2, busy2, done2}), 0);
    rst_n = 1;
    @(negedge clk);
    foreach (vecs[i])
      run_op(0, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
             int'(vecs[i].es), vecs[i].ec, vecs[i].eo);
    // A start arriving mid-operation must be dropped, not queued.
    a = 8'h10; b = 8'h20; sub = 0; cin = 0; start8 = 1;
    @(negedge clk);
    start8 = 0;
    ndone = 0;
    lat = -1;
    for (int k = 0; k < 15; k++) begin
      if (k == 3) begin start8 = 1; a = 8'hAA; b = 8'h55; end
      if (k == 4) start8 = 0;
      if (done8) begin ndone++; if (lat < 0) lat = k; end
      @(negedge clk);
    end
    chk("ign_done_cnt", ndone, 1);
    chk("ign_latency", lat, 8);
    chk("ign_sum", int'(sum8), 8'h30);
    // Asynchronous reset after the 4th bit edge abandons the operation.
    a = 8'h3C; b = 8'h05; start8 = 1;
    @(negedge clk);
    start8 = 0;
    repeat (4) @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("arst_sum", int'(sum8), 0);
    chk("arst_flags", int'({cout8, ovf8, busy8, done8}), 0);
    ndone = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 12; k++) begin
      if (done8 || busy8) ndone++;
      @(negedge clk);
    end
    chk("arst_no_done", ndone, 0);
    run_op(0, 8'h01, 8'h01, 0, 0, 8'h02, 0, 0);
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      model(8, int'(ra), int'(rb), rs, rc, es, ec, eo);
      run_op(0, ra, rb, rs, rc, es, ec, eo);
    end
    for (int i = 0; i < 64; i++) begin
      ra = 8'(i & 3); rb = 8'((i >> 2) & 3); rc = i[4]; rs = i[5];
      model(2, int'(ra), int'(rb), rs, rc, es, ec, eo);
      run_op(1, ra, rb, rs, rc, es, ec, eo);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
